// File: rtl/combiner_sched_if.sv
// Handshake bundle between the entropy coder, combiner_sched and the combiner:
// an upstream word stream (s_*) and a downstream bundle stream (out_*).
interface combiner_sched_if #(
  parameter int N_WORDS    = 4,
  parameter int MAX_LENGTH = 20,
  parameter int LEN_W      = 5,
  parameter int BLOCK_SIZE = 64
);
  localparam int PAD_W = $clog2(BLOCK_SIZE);

  logic [MAX_LENGTH-1:0]         s_word;
  logic [LEN_W-1:0]              s_length;
  logic                          s_last;
  logic                          s_valid;
  logic                          s_ready;
  logic [N_WORDS*MAX_LENGTH-1:0] out_words;
  logic [N_WORDS*LEN_W-1:0]      out_lengths;
  logic                          out_valid;
  logic                          out_ready;
  logic                          out_last;
  logic [PAD_W-1:0]              out_pad_bits;

  modport master (
    output s_word, s_length, s_last, s_valid, out_ready,
    input  s_ready, out_words, out_lengths, out_valid, out_last, out_pad_bits
  );

  modport slave (
    input  s_word, s_length, s_last, s_valid, out_ready,
    output s_ready, out_words, out_lengths, out_valid, out_last, out_pad_bits
  );
endinterface

// File: rtl/combiner_sched.sv
// Groups codewords into N_WORDS-slot bundles for the combiner and tracks the
// bit position modulo BLOCK_SIZE so the image's last bundle carries its pad count.
module combiner_sched #(
  parameter int N_WORDS    = 4,
  parameter int MAX_LENGTH = 20,
  parameter int LEN_W      = 5,
  parameter int BLOCK_SIZE = 64
) (
  input logic              clk,
  input logic              aresetn,
  combiner_sched_if.slave  bus
);
  localparam int PAD_W = $clog2(BLOCK_SIZE);
  localparam int IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int WW    = N_WORDS * MAX_LENGTH;
  localparam int LW    = N_WORDS * LEN_W;

  typedef enum logic {FILL, PEND} state_t;

  state_t                r_state, w_state_nxt;
  logic [IDX_W-1:0]      r_idx;
  logic [PAD_W-1:0]      r_bcnt;
  logic [WW-1:0]         r_fill_words;
  logic [LW-1:0]         r_fill_lens;
  logic                  r_pend_last;
  logic [PAD_W-1:0]      r_pend_pad;
  logic [WW-1:0]         r_out_words;
  logic [LW-1:0]         r_out_lens;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic [PAD_W-1:0]      r_out_pad;

  logic                  w_accept;
  logic                  w_drain;
  logic                  w_out_free;
  logic                  w_complete;
  logic [PAD_W-1:0]      w_bcnt_sum;
  logic [PAD_W-1:0]      w_pad;
  logic [WW-1:0]         w_slot_words;
  logic [LW-1:0]         w_slot_lens;
  logic                  w_xfer_new;
  logic                  w_xfer_pend;
  logic                  w_to_pend;

  assign bus.s_ready      = (r_state == FILL);
  assign bus.out_words    = r_out_words;
  assign bus.out_lengths  = r_out_lens;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_last     = r_out_last;
  assign bus.out_pad_bits = r_out_pad;

  assign w_accept   = bus.s_valid && (r_state == FILL);
  assign w_drain    = r_out_valid && bus.out_ready;
  assign w_out_free = !r_out_valid || bus.out_ready;
  assign w_complete = w_accept && ((r_idx == IDX_W'(N_WORDS - 1)) || bus.s_last);
  // BLOCK_SIZE is a power of two, so the modulo is plain truncation
  assign w_bcnt_sum = r_bcnt + PAD_W'(bus.s_length);
  assign w_pad      = PAD_W'(0) - w_bcnt_sum;

  // Fill register as it looks with the incoming word merged into slot idx
  always_comb begin
    w_slot_words = r_fill_words;
    w_slot_lens  = r_fill_lens;
    if (w_accept) begin
      for (int i = 0; i < N_WORDS; i++) begin
        if (i == int'(r_idx)) begin
          w_slot_words[(N_WORDS-1-i)*MAX_LENGTH +: MAX_LENGTH] = bus.s_word;
          w_slot_lens[(N_WORDS-1-i)*LEN_W +: LEN_W]            = bus.s_length;
        end else if (i > int'(r_idx) && bus.s_last) begin
          w_slot_words[(N_WORDS-1-i)*MAX_LENGTH +: MAX_LENGTH] = '0;
          w_slot_lens[(N_WORDS-1-i)*LEN_W +: LEN_W]            = '0;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_xfer_new  = 1'b0;
    w_xfer_pend = 1'b0;
    w_to_pend   = 1'b0;
    case (r_state)
      FILL: begin
        if (w_complete) begin
          if (w_out_free) begin
            w_xfer_new = 1'b1;
          end else begin
            w_to_pend   = 1'b1;
            w_state_nxt = PEND;
          end
        end
      end
      PEND: begin
        if (w_drain) begin
          w_xfer_pend = 1'b1;
          w_state_nxt = FILL;
        end
      end
      default: w_state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) r_state <= FILL;
    else          r_state <= w_state_nxt;
  end

  // Fill stage: slot index, bit counter and the (possibly parked) bundle
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_idx        <= '0;
      r_bcnt       <= '0;
      r_fill_words <= '0;
      r_fill_lens  <= '0;
      r_pend_last  <= 1'b0;
      r_pend_pad   <= '0;
    end else begin
      if (w_accept) begin
        r_bcnt <= (w_complete && bus.s_last) ? '0 : w_bcnt_sum;
        if (w_xfer_new) begin
          r_fill_words <= '0;
          r_fill_lens  <= '0;
          r_idx        <= '0;
        end else if (w_to_pend) begin
          r_fill_words <= w_slot_words;
          r_fill_lens  <= w_slot_lens;
          r_idx        <= '0;
          r_pend_last  <= bus.s_last;
          r_pend_pad   <= bus.s_last ? w_pad : '0;
        end else begin
          r_fill_words <= w_slot_words;
          r_fill_lens  <= w_slot_lens;
          r_idx        <= r_idx + IDX_W'(1);
        end
      end
      if (w_xfer_pend) begin
        r_fill_words <= '0;
        r_fill_lens  <= '0;
        r_pend_last  <= 1'b0;
        r_pend_pad   <= '0;
      end
    end
  end

  // Output stage: loaded straight from the merged fill or from a parked bundle
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_out_words <= '0;
      r_out_lens  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_pad   <= '0;
    end else if (w_xfer_new) begin
      r_out_words <= w_slot_words;
      r_out_lens  <= w_slot_lens;
      r_out_valid <= 1'b1;
      r_out_last  <= bus.s_last;
      r_out_pad   <= bus.s_last ? w_pad : '0;
    end else if (w_xfer_pend) begin
      r_out_words <= r_fill_words;
      r_out_lens  <= r_fill_lens;
      r_out_valid <= 1'b1;
      r_out_last  <= r_pend_last;
      r_out_pad   <= r_pend_pad;
    end else if (w_drain) begin
      r_out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_combiner_sched.sv
// Directed bench for combiner_sched: hand-computed bundles, pad counts,
// backpressure, asynchronous reset and sustained throughput.
module tb_combiner_sched;
  localparam int N_WORDS    = 4;
  localparam int MAX_LENGTH = 20;
  localparam int LEN_W      = 5;
  localparam int BLOCK_SIZE = 64;

  logic clk;
  logic aresetn;
  int   n_checks;
  int   n_fail;

  combiner_sched_if #(
    .N_WORDS(N_WORDS), .MAX_LENGTH(MAX_LENGTH), .LEN_W(LEN_W), .BLOCK_SIZE(BLOCK_SIZE)
  ) bus ();

  combiner_sched #(
    .N_WORDS(N_WORDS), .MAX_LENGTH(MAX_LENGTH), .LEN_W(LEN_W), .BLOCK_SIZE(BLOCK_SIZE)
  ) dut (
    .clk     (clk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [19:0] w, input logic [4:0] len, input logic last);
    bus.s_word   = w;
    bus.s_length = len;
    bus.s_last   = last;
    bus.s_valid  = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [19:0] sus_word(input int k);
    return 20'(k) * 20'h01011;
  endfunction

  logic [79:0] exp_w;

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    bus.s_word   = '0;
    bus.s_length = '0;
    bus.s_last   = 1'b0;
    bus.s_valid  = 1'b0;
    bus.out_ready = 1'b1;
    aresetn      = 1'b1;
    #1 aresetn   = 1'b0;
    #1;
    check_eq("rst_valid", bus.out_valid, 1'b0);
    check_eq("rst_last", bus.out_last, 1'b0);
    check_eq("rst_pad", bus.out_pad_bits, 6'd0);
    check_eq("rst_words", bus.out_words, 80'd0);
    check_eq("rst_lens", bus.out_lengths, 20'd0);
    check_eq("rst_sready", bus.s_ready, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk) aresetn = 1'b1;
    @(posedge clk);
    #1;

    // Full bundle
    send(20'hAA000, 5'd8, 1'b0);
    send(20'hB0000, 5'd4, 1'b0);
    send(20'hCCC00, 5'd12, 1'b0);
    check_eq("full_early", bus.out_valid, 1'b0);
    send(20'hDDDD0, 5'd16, 1'b0);
    check_eq("full_valid", bus.out_valid, 1'b1);
    check_eq("full_words", bus.out_words, {20'hAA000, 20'hB0000, 20'hCCC00, 20'hDDDD0});
    check_eq("full_lens", bus.out_lengths, {5'd8, 5'd4, 5'd12, 5'd16});
    check_eq("full_last", bus.out_last, 1'b0);
    check_eq("full_pad", bus.out_pad_bits, 6'd0);

    // Flush: 40 + 20 + 20 = 80 bits, 16 into the block, 48 to pad
    send(20'h12345, 5'd20, 1'b0);
    check_eq("full_pulse", bus.out_valid, 1'b0);
    send(20'hFFFFF, 5'd20, 1'b1);
    check_eq("flush_valid", bus.out_valid, 1'b1);
    check_eq("flush_words", bus.out_words, {20'h12345, 20'hFFFFF, 20'h0, 20'h0});
    check_eq("flush_lens", bus.out_lengths, {5'd20, 5'd20, 5'd0, 5'd0});
    check_eq("flush_last", bus.out_last, 1'b1);
    check_eq("flush_pad", bus.out_pad_bits, 6'd48);
    idle();
    check_eq("flush_drain", bus.out_valid, 1'b0);

    // Exact block, then zero-length and bit-counter restart cases
    send(20'h11110, 5'd16, 1'b0);
    send(20'h22220, 5'd16, 1'b0);
    send(20'h33330, 5'd16, 1'b0);
    send(20'h44440, 5'd16, 1'b1);
    check_eq("exact_last", bus.out_last, 1'b1);
    check_eq("exact_pad", bus.out_pad_bits, 6'd0);
    check_eq("exact_lens", bus.out_lengths, {5'd16, 5'd16, 5'd16, 5'd16});
    send(20'hABCDE, 5'd0, 1'b1);
    check_eq("zero_valid", bus.out_valid, 1'b1);
    check_eq("zero_lens", bus.out_lengths, 20'd0);
    check_eq("zero_pad", bus.out_pad_bits, 6'd0);
    check_eq("zero_words", bus.out_words, {20'hABCDE, 20'h0, 20'h0, 20'h0});
    send(20'hF8000, 5'd5, 1'b1);
    check_eq("restart_pad", bus.out_pad_bits, 6'd59);
    send(20'h77777, 5'd0, 1'b0);
    send(20'hC3000, 5'd8, 1'b1);
    check_eq("slot0_lens", bus.out_lengths, {5'd0, 5'd8, 5'd0, 5'd0});
    check_eq("slot0_pad", bus.out_pad_bits, 6'd56);
    check_eq("slot0_words", bus.out_words, {20'h77777, 20'hC3000, 20'h0, 20'h0});
    idle();

    // Backpressure
    send(20'hA0001, 5'd1, 1'b0);
    send(20'hA0002, 5'd2, 1'b0);
    send(20'hA0003, 5'd3, 1'b0);
    bus.out_ready = 1'b0;
    send(20'hA0004, 5'd4, 1'b0);
    check_eq("bp_a_valid", bus.out_valid, 1'b1);
    check_eq("bp_a_sready", bus.s_ready, 1'b1);
    send(20'hB0001, 5'd5, 1'b0);
    send(20'hB0002, 5'd6, 1'b0);
    send(20'hB0003, 5'd7, 1'b0);
    check_eq("bp_fill_sready", bus.s_ready, 1'b1);
    send(20'hB0004, 5'd8, 1'b0);
    check_eq("bp_sready_low", bus.s_ready, 1'b0);
    check_eq("bp_hold_words", bus.out_words, {20'hA0001, 20'hA0002, 20'hA0003, 20'hA0004});
    send(20'hEEEEE, 5'd9, 1'b0);
    send(20'hEEEEE, 5'd9, 1'b0);
    check_eq("bp_stall_sready", bus.s_ready, 1'b0);
    check_eq("bp_stall_valid", bus.out_valid, 1'b1);
    check_eq("bp_stall_lens", bus.out_lengths, {5'd1, 5'd2, 5'd3, 5'd4});
    bus.s_valid   = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check_eq("bp_b_valid", bus.out_valid, 1'b1);
    check_eq("bp_b_words", bus.out_words, {20'hB0001, 20'hB0002, 20'hB0003, 20'hB0004});
    check_eq("bp_b_lens", bus.out_lengths, {5'd5, 5'd6, 5'd7, 5'd8});
    check_eq("bp_b_sready", bus.s_ready, 1'b1);
    bus.out_ready = 1'b1;
    idle();
    check_eq("bp_drain", bus.out_valid, 1'b0);

    // Asynchronous reset mid-fill with a bundle still held
    bus.out_ready = 1'b0;
    send(20'hC0001, 5'd1, 1'b0);
    send(20'hC0002, 5'd1, 1'b0);
    send(20'hC0003, 5'd1, 1'b0);
    send(20'hC0004, 5'd1, 1'b0);
    send(20'hD0001, 5'd2, 1'b0);
    send(20'hD0002, 5'd2, 1'b0);
    check_eq("prerst_valid", bus.out_valid, 1'b1);
    bus.s_valid = 1'b0;
    #2 aresetn = 1'b0;
    #1;
    check_eq("arst_valid", bus.out_valid, 1'b0);
    check_eq("arst_words", bus.out_words, 80'd0);
    check_eq("arst_sready", bus.s_ready, 1'b1);
    #3 aresetn = 1'b1;
    bus.out_ready = 1'b1;
    idle();
    check_eq("arst_quiet", bus.out_valid, 1'b0);
    send(20'hE0001, 5'd3, 1'b0);
    send(20'hE0002, 5'd3, 1'b0);
    send(20'hE0003, 5'd3, 1'b0);
    check_eq("arst_nopart", bus.out_valid, 1'b0);
    send(20'hE0004, 5'd3, 1'b0);
    check_eq("arst_new_words", bus.out_words, {20'hE0001, 20'hE0002, 20'hE0003, 20'hE0004});
    check_eq("arst_new_lens", bus.out_lengths, {5'd3, 5'd3, 5'd3, 5'd3});
    idle();

    // Sustained rate: 12 words, a bundle every 4th accept
    for (int k = 1; k <= 12; k++) begin
      check_eq("sus_sready", bus.s_ready, 1'b1);
      send(sus_word(k), 5'(k), 1'b0);
      if (k % 4 == 0) begin
        for (int j = 0; j < 4; j++) exp_w[(3-j)*20 +: 20] = sus_word(k - 3 + j);
        check_eq("sus_valid", bus.out_valid, 1'b1);
        check_eq("sus_words", bus.out_words, exp_w);
      end else begin
        check_eq("sus_gap", bus.out_valid, 1'b0);
      end
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
